// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, redirect flush and halt/drain control for a 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memtoreg,
    input  logic [4:0]       ex_regaw,
    input  logic             mem_redirect,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t           state_q, state_d;
    logic [2:0]       drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             lu, stall;
    assign lu = ex_memtoreg && ex_regaw != 5'd0 &&
                (ex_regaw == id_rs || (id_uses_rt && ex_regaw == id_rt));
    assign stall = state_q == RUN && !mem_redirect && lu;
    assign stall_count = stall_q;
    assign flush_count = flush_q;
    // Pipeline control: redirect outranks stall; reset forces everything to squash
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halt_ack    = 1'b0;
        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state_q == HALTED) begin
            halt_ack   = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
        end else if (mem_redirect) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state_q == DRAIN) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
        end else if (lu) begin
            idex_flush = 1'b1;
        end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
        end
    end
    // Next state: halt is only accepted in a quiet RUN cycle; drain exits early if halt drops
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: if (!mem_redirect && !lu && halt_req) begin
                state_d = DRAIN;
                drain_d = 3'd4;
            end
            DRAIN: begin
                drain_d = drain_q - 3'd1;
                if (!halt_req) begin
                    state_d = RUN;
                    drain_d = 3'd0;
                end else if (drain_q == 3'd1) begin
                    state_d = HALTED;
                end
            end
            HALTED: state_d = halt_req ? HALTED : RUN;
            default: state_d = RUN;
        endcase
        stall_d = (stall && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
        flush_d = (mem_redirect && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
    end
    // State and saturating event counters with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= 3'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a cycle model
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_regaw = '0;
    logic id_uses_rt = 1'b0, ex_memtoreg = 1'b0, mem_redirect = 1'b0, halt_req = 1'b0;
    logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, halt_ack;
    logic pc_en2, ifid_en2, ifid_flush2, idex_flush2, exmem_flush2, halt_ack2;
    logic [15:0] stall_count, flush_count;
    logic [1:0] stall2, flush2;
    logic [5:0] outs, exp_o, exp_m;
    int checks = 0, fails = 0;
    int m_drain = 0, m_stall = 0, m_flush = 0;
    bit m_halted = 0;

    assign outs = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, halt_ack};

    always #5 clk = ~clk;

    pipe_hazard_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memtoreg(ex_memtoreg), .ex_regaw(ex_regaw), .mem_redirect(mem_redirect),
        .halt_req(halt_req), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halt_ack(halt_ack),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memtoreg(ex_memtoreg), .ex_regaw(ex_regaw), .mem_redirect(mem_redirect),
        .halt_req(halt_req), .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2),
        .idex_flush(idex_flush2), .exmem_flush(exmem_flush2), .halt_ack(halt_ack2),
        .stall_count(stall2), .flush_count(flush2)
    );

    function automatic bit lu_f();
        return ex_memtoreg && ex_regaw != 5'd0 &&
               (ex_regaw == id_rs || (id_uses_rt && ex_regaw == id_rt));
    endfunction

    function automatic logic [1:0] sat2(input int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    // Drive one cycle of inputs at the falling edge and predict the outputs from the rules
    task automatic apply(input bit r, input bit rd, input bit h, input bit mt,
                         input logic [4:0] aw, input logic [4:0] rs, input logic [4:0] rt,
                         input bit ur);
        rst_n = r; mem_redirect = rd; halt_req = h; ex_memtoreg = mt;
        ex_regaw = aw; id_rs = rs; id_rt = rt; id_uses_rt = ur;
        #1;
        if (!rst_n) begin exp_o = 6'b001110; exp_m = 6'b111111; end
        else if (m_halted) begin exp_o = 6'b001001; exp_m = 6'b101001; end
        else if (mem_redirect) begin exp_o = 6'b111110; exp_m = 6'b111111; end
        else if (m_drain > 0) begin exp_o = 6'b011000; exp_m = 6'b111001; end
        else if (lu_f()) begin exp_o = 6'b000100; exp_m = 6'b110101; end
        else begin exp_o = 6'b110000; exp_m = 6'b111111; end
    endtask

    // Advance one clock; the model counts events as unbounded integers
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_drain = 0; m_halted = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (mem_redirect) m_flush++;
            if (m_halted) m_halted = halt_req;
            else if (m_drain > 0) begin
                if (!halt_req) m_drain = 0;
                else if (m_drain == 1) begin m_drain = 0; m_halted = 1; end
                else m_drain--;
            end
            else if (!mem_redirect && lu_f()) m_stall++;
            else if (!mem_redirect && halt_req) m_drain = 4;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(0, i[0], 1, 1, 5'd3, 5'd3, 5'd3, 1);
            checks++;
            if (outs !== 6'b001110) begin fails++; $display("FAIL reset_outs got %b want 001110", outs); end
            tick();
        end
        checks++;
        if ({stall_count, flush_count, stall2, flush2} !== 36'd0) begin
            fails++; $display("FAIL reset_counts got %0d %0d %0d %0d want 0", stall_count, flush_count, stall2, flush2);
        end
    endtask

    task automatic test_load_use();
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (outs !== 6'b110000) begin fails++; $display("FAIL idle_outs got %b want 110000", outs); end
        tick();
        apply(1, 0, 0, 1, 5'd5, 5'd5, 5'd9, 0);
        checks++;
        if ({pc_en, ifid_en, idex_flush, halt_ack} !== 4'b0010) begin
            fails++; $display("FAIL lu_stall got %b want pc0 ifid0 idex1 ack0", {pc_en, ifid_en, idex_flush, halt_ack});
        end
        tick();
        apply(1, 0, 0, 0, 5'd5, 5'd5, 5'd9, 0);
        checks++;
        if (outs !== 6'b110000) begin fails++; $display("FAIL lu_release got %b want 110000", outs); end
        tick();
        checks++;
        if (stall_count !== 16'd1) begin fails++; $display("FAIL lu_count got %0d want 1", stall_count); end
    endtask

    task automatic test_no_stall();
        apply(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
        checks++;
        if (outs !== 6'b110000) begin fails++; $display("FAIL r0_nostall got %b want 110000", outs); end
        tick();
        apply(1, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0);
        checks++;
        if (outs !== 6'b110000) begin fails++; $display("FAIL rt_unused got %b want 110000", outs); end
        tick();
        checks++;
        if (stall_count !== 16'd1) begin fails++; $display("FAIL nostall_count got %0d want 1", stall_count); end
        apply(1, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1);
        checks++;
        if ((outs & exp_m) !== (exp_o & exp_m) || pc_en !== 1'b0) begin
            fails++; $display("FAIL rt_used got %b want %b", outs, exp_o);
        end
        tick();
        checks++;
        if (stall_count !== 16'd2) begin fails++; $display("FAIL rt_count got %0d want 2", stall_count); end
    endtask

    task automatic test_redirect_priority();
        int s0, f0;
        s0 = m_stall; f0 = m_flush;
        apply(1, 1, 0, 1, 5'd4, 5'd4, 5'd0, 0);
        checks++;
        if (outs !== 6'b111110) begin fails++; $display("FAIL redir_lu got %b want 111110", outs); end
        tick();
        checks++;
        if (flush_count !== 16'(f0 + 1) || stall_count !== 16'(s0)) begin
            fails++; $display("FAIL redir_counts got s=%0d f=%0d want s=%0d f=%0d", stall_count, flush_count, s0, f0 + 1);
        end
    endtask

    task automatic test_halt();
        apply(1, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (outs !== 6'b110000) begin fails++; $display("FAIL halt_sample got %b want 110000", outs); end
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 1, 1, 5'd2, 5'd2, 5'd2, 1);
            checks++;
            if ({pc_en, ifid_en, ifid_flush, halt_ack} !== 4'b0110) begin
                fails++; $display("FAIL drain_%0d got %b want pc0 ifid1 iff1 ack0", i, {pc_en, ifid_en, ifid_flush, halt_ack});
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 1, 0, 0, 0, 0, 0);
            checks++;
            if ({pc_en, ifid_flush, halt_ack} !== 3'b011) begin
                fails++; $display("FAIL halted_%0d got %b want pc0 iff1 ack1", i, {pc_en, ifid_flush, halt_ack});
            end
            tick();
        end
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ((outs & exp_m) !== (exp_o & exp_m) || halt_ack !== 1'b1) begin
            fails++; $display("FAIL unhalt_cycle got %b want %b", outs, exp_o);
        end
        tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (outs !== 6'b110000) begin fails++; $display("FAIL resume got %b want 110000", outs); end
        tick();
    endtask

    task automatic test_drain_abort();
        int f0;
        bit seen_ack = 0;
        apply(1, 0, 1, 0, 0, 0, 0, 0);
        tick();
        apply(1, 0, 1, 0, 0, 0, 0, 0);
        seen_ack |= halt_ack;
        checks++;
        if ((outs & exp_m) !== (exp_o & exp_m)) begin fails++; $display("FAIL abort_drain1 got %b want %b", outs, exp_o); end
        tick();
        f0 = m_flush;
        apply(1, 1, 1, 0, 0, 0, 0, 0);
        seen_ack |= halt_ack;
        checks++;
        if (outs !== 6'b111110) begin fails++; $display("FAIL drain_redirect got %b want 111110", outs); end
        tick();
        checks++;
        if (flush_count !== 16'(f0 + 1)) begin fails++; $display("FAIL drain_flush_cnt got %0d want %0d", flush_count, f0 + 1); end
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        seen_ack |= halt_ack;
        checks++;
        if ({pc_en, ifid_flush} !== 2'b01) begin fails++; $display("FAIL abort_cycle got %b want pc0 iff1", {pc_en, ifid_flush}); end
        tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        seen_ack |= halt_ack;
        checks++;
        if (outs !== 6'b110000 || seen_ack) begin
            fails++; $display("FAIL abort_run got %b ack_seen %0d want 110000 ack_seen 0", outs, seen_ack);
        end
        tick();
    endtask

    task automatic test_saturation();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin apply(1, 1, 0, 0, 0, 0, 0, 0); tick(); end
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 0, 1, 5'd6, 5'd6, 0, 0); tick();
            apply(1, 0, 0, 0, 0, 0, 0, 0); tick();
        end
        checks++;
        if (flush2 !== 2'd3 || flush_count !== 16'd5 || stall2 !== 2'd3 || stall_count !== 16'd4) begin
            fails++; $display("FAIL saturate got f2=%0d f=%0d s2=%0d s=%0d want 3 5 3 4", flush2, flush_count, stall2, stall_count);
        end
        for (int i = 0; i < 6; i++) begin apply(1, 0, 1, 0, 0, 0, 0, 0); tick(); end
        apply(1, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (halt_ack !== 1'b1) begin fails++; $display("FAIL sat_halted got ack=%b want 1", halt_ack); end
        apply(0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (outs !== 6'b001110) begin fails++; $display("FAIL halted_reset got %b want 001110", outs); end
        tick();
        apply(1, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (outs !== 6'b110000 || {stall_count, flush_count, stall2, flush2} !== 36'd0) begin
            fails++; $display("FAIL post_reset got %b s=%0d f=%0d want 110000 0 0", outs, stall_count, flush_count);
        end
        tick();
    endtask

    task automatic test_random();
        bit h = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) h = !h;
            apply($urandom_range(63) != 0, $urandom_range(7) == 0, h, $urandom_range(1) == 1,
                  5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(1) == 1);
            checks++;
            if ((outs & exp_m) !== (exp_o & exp_m)) begin
                fails++; $display("FAIL rand_outs cyc %0d got %b want %b mask %b", i, outs, exp_o, exp_m);
            end
            tick();
            checks++;
            if ({stall_count, flush_count, stall2, flush2} !== {16'(m_stall), 16'(m_flush), sat2(m_stall), sat2(m_flush)}) begin
                fails++; $display("FAIL rand_counts cyc %0d got %0d %0d %0d %0d want %0d %0d", i, stall_count, flush_count, stall2, flush2, m_stall, m_flush);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_use();
        test_no_stall();
        test_redirect_priority();
        test_halt();
        test_drain_abort();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the event counters.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: synchronous, active-low reset.
REQ-004 Port id_rs, input, 5: rs field of the instruction in ID.
REQ-005 Port id_rt, input, 5: rt field of the instruction in ID.
REQ-006 Port id_uses_rt, input, 1: the instruction in ID reads rt as a source.
REQ-007 Port ex_memtoreg, input, 1: the instruction in EX is a load.
REQ-008 Port ex_regaw, input, 5: destination register of the instruction in EX.
REQ-009 Port mem_redirect, input, 1: a taken branch or jump in MEM is redirecting the PC this cycle.
REQ-010 Port halt_req, input, 1: level request to drain and freeze the pipeline.
REQ-011 Port pc_en, output, 1: PC register load enable.
REQ-012 Port ifid_en, output, 1: IF/ID register load enable.
REQ-013 Port ifid_flush, output, 1: load a bubble (all zeros) into IF/ID.
REQ-014 Port idex_flush, output, 1: zero all control bits entering ID/EX.
REQ-015 Port exmem_flush, output, 1: zero all control bits entering EX/MEM.
REQ-016 Port halt_ack, output, 1: the pipeline is empty and frozen.
REQ-017 Port stall_count, output, CNT_W: number of load-use stall cycles.
REQ-018 Port flush_count, output, CNT_W: number of redirect flush cycles.

Function
REQ-019 The block SHALL implement three states, RUN, DRAIN and HALTED, plus a 3-bit drain counter.
REQ-020 Load-use hazard (lu) SHALL be ex_memtoreg & (ex_regaw != 0) & ((ex_regaw == id_rs) | (id_uses_rt & (ex_regaw == id_rt))).
REQ-021 In RUN with mem_redirect=1, outputs SHALL be pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1 and exmem_flush=1 in that same cycle, so all three wrong-path instructions are squashed with zero added latency.
REQ-022 In RUN with mem_redirect=0 and lu=1, outputs SHALL be pc_en=0, ifid_en=0 and idex_flush=1 for exactly one cycle (one bubble); the stall clears itself because the bubble removes the hazard.
REQ-023 mem_redirect SHALL take priority over lu in the same cycle; in that case no stall is counted.
REQ-024 In RUN with neither event, outputs SHALL be pc_en=1, ifid_en=1, all flushes 0, halt_ack=0.
REQ-025 In RUN, halt_req=1 with no redirect and no lu SHALL move the block to DRAIN next cycle with the drain counter set to 4; in a cycle with a redirect or lu, that event is served first and halt_req is re-sampled the following cycle.
REQ-026 In DRAIN, outputs SHALL be pc_en=0, ifid_en=1 and ifid_flush=1 (fetch frozen, bubbles injected), and the drain counter SHALL decrement every cycle.
REQ-027 A mem_redirect in DRAIN SHALL force pc_en=1 and assert all three flushes that cycle; the drain counter still decrements.
REQ-028 When the drain counter reaches 0 in DRAIN, the block SHALL move to HALTED if halt_req=1, otherwise to RUN.
REQ-029 halt_req deasserted mid-DRAIN SHALL cause a return to RUN next cycle with the PC intact; no instruction is lost or duplicated.
REQ-030 In HALTED, outputs SHALL be halt_ack=1, pc_en=0 and ifid_flush=1; deassertion of halt_req SHALL give RUN next cycle with halt_ack=0.
REQ-031 stall_count SHALL increment by 1 per REQ-022 cycle, and flush_count SHALL increment by 1 per redirect cycle in any state; both SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 lu SHALL be ignored in DRAIN and HALTED.

Reset
REQ-033 While rst_n=0 at a rising edge, the block SHALL load state=RUN, drain counter=0 and both counters=0.
REQ-034 While rst_n=0, outputs SHALL be pc_en=0, ifid_en=0, all flushes=1 and halt_ack=0, regardless of state.
REQ-035 A reset during DRAIN or HALTED SHALL abandon the drain; the first cycle after release is RUN.

Verification
REQ-036 ex_memtoreg=1, ex_regaw=5, id_rs=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; stall_count 0->1.
REQ-037 Same as REQ-036 but ex_regaw=0, or id_rt match with id_uses_rt=0 -> no stall; stall_count unchanged.
REQ-038 mem_redirect=1 together with an active lu -> pc_en=1 and all three flushes=1; flush_count +1; stall_count +0.
REQ-039 halt_req=1 held from RUN -> 4 DRAIN cycles with pc_en=0, then halt_ack=1; drop halt_req -> RUN and pc_en=1 one cycle later.
REQ-040 halt_req dropped after 2 DRAIN cycles -> RUN next cycle, halt_ack never asserted; a redirect injected in DRAIN -> pc_en=1 that cycle, flush_count +1.
REQ-041 Preload a counter to 2^CNT_W-2 with CNT_W=2, apply 3 redirects -> flush_count stops at 3; rst_n=0 in HALTED -> both counters 0, RUN after release.
